instr_fetch_unit: RTL and testbench

- Front-end sequencer that drives the 8-bit `counter` address into the instruction memory and consumes its combinational `instruct` output.
- Registers each fetched byte into an instruction register and hands it to decode over a valid/ready handshake.
- Supports branch/jump redirect with flush, decode back-pressure, and a halt state.

---
 rtl/instr_fetch_unit_pkg.sv | 15 +
 rtl/instr_fetch_unit_if.sv | 51 +++++
 rtl/instr_fetch_unit_pc_reg.sv | 40 ++++
 rtl/instr_fetch_unit.sv | 87 ++++++++
 tb/tb_instr_fetch_unit.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end.
// Decode and branch units import the same widths and state encoding.
package instr_fetch_unit_pkg;

  localparam int unsigned IfuAddrW   = 8;
  localparam int unsigned IfuDataW   = 8;
  localparam int unsigned IfuCntW    = 16;
  localparam logic [7:0]  IfuResetPc = 8'h00;

  typedef enum logic [0:0] {
    StRun  = 1'b0,
    StHalt = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus between the fetch unit, the instruction memory and decode.
// master is the fetch unit side; slave is the memory/decode/control side.
interface instr_fetch_unit_if
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = IfuAddrW,
  parameter int unsigned DATA_W = IfuDataW,
  parameter int unsigned CNT_W  = IfuCntW
);

  logic [ADDR_W-1:0] counter;
  logic [DATA_W-1:0] instruct;
  logic [DATA_W-1:0] ir_out;
  logic [ADDR_W-1:0] ir_pc;
  logic              ir_valid;
  logic              ir_ready;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_addr;
  logic              halt;
  logic              halted;
  logic [CNT_W-1:0]  fetch_cnt;

  modport master (
    output counter,
    input  instruct,
    output ir_out,
    output ir_pc,
    output ir_valid,
    input  ir_ready,
    input  redirect,
    input  redirect_addr,
    input  halt,
    output halted,
    output fetch_cnt
  );

  modport slave (
    input  counter,
    output instruct,
    input  ir_out,
    input  ir_pc,
    input  ir_valid,
    output ir_ready,
    output redirect,
    output redirect_addr,
    output halt,
    input  halted,
    input  fetch_cnt
  );

endinterface

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter: redirect load beats increment; otherwise holds.
// The register output drives the memory address directly.
module instr_fetch_unit_pc_reg
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = IfuAddrW,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IfuResetPc)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = redirect_addr;
    end else if (inc) begin
      // Natural modulo-2^ADDR_W wrap, no flag.
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch sequencer: addresses the instruction memory, latches each byte into
// the instruction register and hands it to decode over valid/ready.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = IfuAddrW,
  parameter int unsigned       DATA_W   = IfuDataW,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IfuResetPc),
  parameter int unsigned       CNT_W    = IfuCntW
) (
  input logic               clk,
  input logic               reset,
  instr_fetch_unit_if.master bus
);

  fetch_state_e      state_q;
  logic              halted_q;
  logic [DATA_W-1:0] ir_out_q;
  logic [ADDR_W-1:0] ir_pc_q;
  logic              ir_valid_q;
  logic [CNT_W-1:0]  fetch_cnt_q;

  logic              accept;
  logic              load;
  logic              pc_inc;
  logic [ADDR_W-1:0] pc;

  assign accept = ir_valid_q & bus.ir_ready;
  assign load   = (state_q == StRun) & (~ir_valid_q | accept);
  // The PC only advances when the instruction register actually takes a byte.
  assign pc_inc = load & ~bus.redirect & ~bus.halt;

  instr_fetch_unit_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .reset         (reset),
    .redirect      (bus.redirect),
    .redirect_addr (bus.redirect_addr),
    .inc           (pc_inc),
    .pc            (pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StRun;
      halted_q    <= 1'b0;
      ir_out_q    <= '0;
      ir_pc_q     <= '0;
      ir_valid_q  <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      // A handshake counts even in the cycle a redirect kills the register.
      if (accept) begin
        fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
      end

      if (bus.redirect) begin
        ir_valid_q <= 1'b0;
        state_q    <= bus.halt ? StHalt : StRun;
        halted_q   <= bus.halt;
      end else if (bus.halt) begin
        state_q  <= StHalt;
        halted_q <= 1'b1;
        if (accept) begin
          ir_valid_q <= 1'b0;
        end
      end else if (load) begin
        ir_out_q   <= bus.instruct;
        ir_pc_q    <= pc;
        ir_valid_q <= 1'b1;
      end else if (accept) begin
        // Halted: drain the last held byte without refilling.
        ir_valid_q <= 1'b0;
      end
    end
  end

  assign bus.counter   = pc;
  assign bus.ir_out    = ir_out_q;
  assign bus.ir_pc     = ir_pc_q;
  assign bus.ir_valid  = ir_valid_q;
  assign bus.halted    = halted_q;
  assign bus.fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed walk-through of the fetch, stall,
// redirect, halt, wrap and async-reset cases, then randomized traffic.
module tb_instr_fetch_unit;

  typedef struct {
    logic [7:0] pc;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [7:0] mem [256];

  instr_fetch_unit_if #(.ADDR_W(8), .DATA_W(8), .CNT_W(16)) bus ();
  instr_fetch_unit_if #(.ADDR_W(8), .DATA_W(8), .CNT_W(16)) bus2 ();

  assign bus.instruct  = mem[bus.counter];
  assign bus2.instruct = mem[bus2.counter];

  instr_fetch_unit #(
    .ADDR_W   (8),
    .DATA_W   (8),
    .RESET_PC (8'h00),
    .CNT_W    (16)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  instr_fetch_unit #(
    .ADDR_W   (8),
    .DATA_W   (8),
    .RESET_PC (8'hFE),
    .CNT_W    (16)
  ) u_dut_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the accepted-instruction stream is the sequential
  // address run starting at the last redirect (or reset) target.
  exp_t        exp_q[$];
  logic [7:0]  gen_pc;
  logic        m_halt;
  logic [15:0] m_cnt;
  logic        mon_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic refill();
    while (exp_q.size() < 4) begin
      exp_q.push_back('{pc: gen_pc, data: mem[gen_pc]});
      gen_pc = gen_pc + 8'd1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    gen_pc = 8'h00;
    m_halt = 1'b0;
    m_cnt  = '0;
    #2;
    reset = 1'b0;
    #1;
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("halted", 32'(bus.halted), 32'(m_halt));
      chk("fetch_cnt", 32'(bus.fetch_cnt), 32'(m_cnt));
      if (bus.ir_valid && bus.ir_ready) begin
        if (exp_q.size() == 0) begin
          chk("accept_with_empty_queue", 32'(1), 32'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("ir_pc", 32'(bus.ir_pc), 32'(e.pc));
          chk("ir_out", 32'(bus.ir_out), 32'(e.data));
        end
        m_cnt = m_cnt + 16'd1;
      end
      if (bus.redirect) m_halt = bus.halt;
      else if (bus.halt) m_halt = 1'b1;
    end
  end

  initial begin
    logic [7:0] m40;
    logic [7:0] m10;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h11;
    mem[1] = 8'h22;
    mem[2] = 8'h33;
    m40 = mem[8'h40];
    m10 = mem[8'h10];

    reset              = 1'b1;
    bus.ir_ready       = 1'b1;
    bus.redirect       = 1'b0;
    bus.redirect_addr  = '0;
    bus.halt           = 1'b0;
    bus2.ir_ready      = 1'b1;
    bus2.redirect      = 1'b0;
    bus2.redirect_addr = '0;
    bus2.halt          = 1'b0;

    // Straight-line fetch plus the wrapping instance.
    do_reset();
    chk("rst_counter", 32'(bus.counter), 32'h00);
    chk("rst_ir_valid", 32'(bus.ir_valid), 32'h0);
    chk("rst_ir_out", 32'(bus.ir_out), 32'h0);
    chk("rst_ir_pc", 32'(bus.ir_pc), 32'h0);
    chk("rst_halted", 32'(bus.halted), 32'h0);
    chk("rst_fetch_cnt", 32'(bus.fetch_cnt), 32'h0);
    chk("wrap_rst_counter", 32'(bus2.counter), 32'hFE);
    step();
    chk("f1_counter", 32'(bus.counter), 32'h01);
    chk("f1_valid", 32'(bus.ir_valid), 32'h1);
    chk("f1_ir_out", 32'(bus.ir_out), 32'h11);
    chk("f1_ir_pc", 32'(bus.ir_pc), 32'h00);
    chk("wrap1_counter", 32'(bus2.counter), 32'hFF);
    chk("wrap1_ir_pc", 32'(bus2.ir_pc), 32'hFE);
    step();
    chk("f2_counter", 32'(bus.counter), 32'h02);
    chk("f2_ir_out", 32'(bus.ir_out), 32'h22);
    chk("f2_ir_pc", 32'(bus.ir_pc), 32'h01);
    chk("wrap2_counter", 32'(bus2.counter), 32'h00);
    chk("wrap2_ir_pc", 32'(bus2.ir_pc), 32'hFF);
    step();
    chk("f3_counter", 32'(bus.counter), 32'h03);
    chk("f3_ir_out", 32'(bus.ir_out), 32'h33);
    chk("f3_ir_pc", 32'(bus.ir_pc), 32'h02);
    chk("wrap3_counter", 32'(bus2.counter), 32'h01);
    chk("wrap3_ir_pc", 32'(bus2.ir_pc), 32'h00);
    step();
    chk("f4_fetch_cnt", 32'(bus.fetch_cnt), 32'd3);

    // Stall on 0x22 for three cycles.
    do_reset();
    step();
    step();
    chk("st_pre_ir_out", 32'(bus.ir_out), 32'h22);
    bus.ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_ir_out", 32'(bus.ir_out), 32'h22);
      chk("st_ir_pc", 32'(bus.ir_pc), 32'h01);
      chk("st_counter", 32'(bus.counter), 32'h02);
      chk("st_valid", 32'(bus.ir_valid), 32'h1);
    end
    bus.ir_ready = 1'b1;
    step();
    chk("st_rel_ir_out", 32'(bus.ir_out), 32'h33);
    chk("st_rel_ir_pc", 32'(bus.ir_pc), 32'h02);
    chk("st_rel_cnt", 32'(bus.fetch_cnt), 32'd2);
    step();
    step();
    step();
    chk("pre_rd_ir_pc", 32'(bus.ir_pc), 32'h05);
    chk("pre_rd_cnt", 32'(bus.fetch_cnt), 32'd5);

    // Redirect while stalled on ir_pc=5.
    bus.ir_ready      = 1'b0;
    bus.redirect      = 1'b1;
    bus.redirect_addr = 8'h40;
    step();
    chk("rd_valid", 32'(bus.ir_valid), 32'h0);
    chk("rd_counter", 32'(bus.counter), 32'h40);
    chk("rd_cnt", 32'(bus.fetch_cnt), 32'd5);
    bus.redirect = 1'b0;
    step();
    chk("rd1_valid", 32'(bus.ir_valid), 32'h1);
    chk("rd1_ir_pc", 32'(bus.ir_pc), 32'h40);
    chk("rd1_ir_out", 32'(bus.ir_out), 32'(m40));
    chk("rd1_counter", 32'(bus.counter), 32'h41);
    chk("rd1_cnt", 32'(bus.fetch_cnt), 32'd5);

    // Halt while holding a stalled instruction, drain, then restart.
    bus.halt = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("h_halted", 32'(bus.halted), 32'h1);
      chk("h_counter", 32'(bus.counter), 32'h41);
      chk("h_valid", 32'(bus.ir_valid), 32'h1);
      chk("h_ir_out", 32'(bus.ir_out), 32'(m40));
    end
    bus.ir_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("hd_valid", 32'(bus.ir_valid), 32'h0);
      chk("hd_cnt", 32'(bus.fetch_cnt), 32'd6);
      chk("hd_counter", 32'(bus.counter), 32'h41);
      chk("hd_halted", 32'(bus.halted), 32'h1);
    end
    bus.halt          = 1'b0;
    bus.redirect      = 1'b1;
    bus.redirect_addr = 8'h10;
    step();
    chk("hr_halted", 32'(bus.halted), 32'h0);
    chk("hr_counter", 32'(bus.counter), 32'h10);
    chk("hr_valid", 32'(bus.ir_valid), 32'h0);
    bus.redirect = 1'b0;
    step();
    chk("hr1_valid", 32'(bus.ir_valid), 32'h1);
    chk("hr1_ir_pc", 32'(bus.ir_pc), 32'h10);
    chk("hr1_ir_out", 32'(bus.ir_out), 32'(m10));
    chk("hr1_counter", 32'(bus.counter), 32'h11);

    // Async reset in the middle of a halted stall.
    bus.ir_ready = 1'b0;
    bus.halt     = 1'b1;
    step();
    chk("ar_pre_halted", 32'(bus.halted), 32'h1);
    chk("ar_pre_valid", 32'(bus.ir_valid), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", 32'(bus.ir_valid), 32'h0);
    chk("ar_halted", 32'(bus.halted), 32'h0);
    chk("ar_cnt", 32'(bus.fetch_cnt), 32'h0);
    chk("ar_counter", 32'(bus.counter), 32'h00);
    bus.halt     = 1'b0;
    bus.ir_ready = 1'b1;

    // Randomized traffic checked by the scoreboard.
    do_reset();
    refill();
    mon_on = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      logic r;
      logic rd;
      logic h;
      logic [7:0] a;
      step();
      r  = ($urandom_range(0, 3) != 0);
      rd = ($urandom_range(0, 19) == 0);
      h  = ($urandom_range(0, 39) == 0);
      a  = 8'($urandom);
      if (rd) begin
        // Only the instruction handed over in this same cycle survives.
        if (bus.ir_valid && r && exp_q.size() > 0) begin
          exp_t f;
          f = exp_q[0];
          exp_q.delete();
          exp_q.push_back(f);
        end else begin
          exp_q.delete();
        end
        gen_pc = a;
      end
      bus.ir_ready      = r;
      bus.redirect      = rd;
      bus.redirect_addr = a;
      bus.halt          = h;
      refill();
    end
    step();
    mon_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
